// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Multi-port ARM register file. R0..R14 are stored and R15 is
//                supplied from outside (PC+8). It has NRD combinational read
//                ports and NWR write ports, an optional write-to-read bypass,
//                and a per-register busy scoreboard for multicycle producers.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int NRD    = 3,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NRD*4-1:0]        ra,
  output logic [NRD*DATA_W-1:0]   rd,
  output logic [NRD-1:0]          rd_busy,
  input  logic [NWR-1:0]          we,
  input  logic [NWR*4-1:0]        wa,
  input  logic [NWR*DATA_W-1:0]   wd,
  input  logic [DATA_W-1:0]       r15,
  input  logic                    busy_set,
  input  logic [3:0]              busy_wa,
  output logic                    any_busy,
  output logic                    wr_pc_err
);

  localparam int         NREG    = 15;
  localparam logic [3:0] PC_ADDR = 4'hF;
  localparam bit         BYP_EN  = (BYPASS != 0);

  // Architectural state
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic              wr_pc_err_q;
  logic              wr_pc_err_d;

  // Per-register decode of this cycle's write ports and busy request
  logic [NREG-1:0]   wr_hit;
  logic [DATA_W-1:0] wr_data [NREG];
  logic [NREG-1:0]   set_hit;

  // 16-entry views indexed directly by a 4-bit read address; entry 15 is the
  // PC, which is never busy and never bypassed.
  logic [DATA_W-1:0] rf_view   [16];
  logic [DATA_W-1:0] byp_view  [16];
  logic [15:0]       hit_view;
  logic [15:0]       set_view;
  logic [15:0]       busy_view;

  // Find, for each register, whether any enabled port writes it and which
  // data wins; ports are scanned upward so the highest index overrides.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NREG; r++) begin
      wr_data[r] = '0;
    end
    for (int j = 0; j < NWR; j++) begin
      for (int r = 0; r < NREG; r++) begin
        if (we[j] && (wa[4*j +: 4] == 4'(r))) begin
          wr_hit[r]  = 1'b1;
          wr_data[r] = wd[DATA_W*j +: DATA_W];
        end
      end
    end
  end

  // Busy request decode; busy_wa of 15 never matches a stored register.
  always_comb begin
    set_hit = '0;
    for (int r = 0; r < NREG; r++) begin
      set_hit[r] = busy_set && (busy_wa == 4'(r));
    end
  end

  // Next-state: register writes, scoreboard (set beats clear), sticky PC error.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      rf_d[r] = wr_hit[r] ? wr_data[r] : rf_q[r];
    end
    busy_d = busy_q;
    for (int r = 0; r < NREG; r++) begin
      if (set_hit[r]) begin
        busy_d[r] = 1'b1;
      end else if (wr_hit[r]) begin
        busy_d[r] = 1'b0;
      end
    end
    wr_pc_err_d = wr_pc_err_q;
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && (wa[4*j +: 4] == PC_ADDR)) begin
        wr_pc_err_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin
        rf_q[r] <= '0;
      end
      busy_q      <= '0;
      wr_pc_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        rf_q[r] <= rf_d[r];
      end
      busy_q      <= busy_d;
      wr_pc_err_q <= wr_pc_err_d;
    end
  end

  // Build the address-indexed views, with R15 mapped to the external PC.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      rf_view[r]  = rf_q[r];
      byp_view[r] = wr_data[r];
    end
    rf_view[15]  = r15;
    byp_view[15] = r15;
    hit_view     = {1'b0, wr_hit};
    set_view     = {1'b0, set_hit};
    busy_view    = {1'b0, busy_q};
  end

  // Read ports: forwarded write data when bypass is enabled, else stored value.
  // A busy register being cleared this cycle is not reported busy when its
  // data is forwarded, unless it is re-marked busy in the same cycle.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [3:0] addr;
    assign addr = ra[4*k +: 4];
    assign rd[DATA_W*k +: DATA_W] = (BYP_EN && hit_view[addr]) ? byp_view[addr]
                                                              : rf_view[addr];
    assign rd_busy[k] = busy_view[addr] &
                        ~(BYP_EN & hit_view[addr] & ~set_view[addr]);
  end

  assign any_busy  = |busy_q;
  assign wr_pc_err = wr_pc_err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Self-checking bench for regfile_mp. Drives one bypass and one
//                non-bypass instance from the same stimulus and checks both
//                against a reference model through an expectation queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int NRD = 3;
  localparam int NWR = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NRD*4-1:0]  ra;
  logic [NWR-1:0]    we;
  logic [NWR*4-1:0]  wa;
  logic [NWR*DW-1:0] wd;
  logic [DW-1:0]     r15;
  logic              busy_set;
  logic [3:0]        busy_wa;

  logic [NRD*DW-1:0] rd_b, rd_n;
  logic [NRD-1:0]    rdb_b, rdb_n;
  logic              any_b, any_n, err_b, err_n;

  regfile_mp #(.DATA_W(DW), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_dut_byp (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_b), .rd_busy(rdb_b),
    .we(we), .wa(wa), .wd(wd), .r15(r15), .busy_set(busy_set),
    .busy_wa(busy_wa), .any_busy(any_b), .wr_pc_err(err_b)
  );

  regfile_mp #(.DATA_W(DW), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_dut_nob (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_n), .rd_busy(rdb_n),
    .we(we), .wa(wa), .wd(wd), .r15(r15), .busy_set(busy_set),
    .busy_wa(busy_wa), .any_busy(any_n), .wr_pc_err(err_n)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] m_rf [15];
  logic [14:0]   m_busy;
  logic          m_err;

  typedef struct { string tag; logic [31:0] val; } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [3:0] a, input bit byp);
    logic [31:0] v;
    if (a == 4'hF) return r15;
    v = m_rf[a];
    if (byp)
      for (int j = 0; j < NWR; j++)
        if (we[j] && wa[4*j +: 4] == a) v = wd[DW*j +: DW];
    return v;
  endfunction

  function automatic logic exp_busy(input logic [3:0] a, input bit byp);
    logic s, c;
    if (a == 4'hF) return 1'b0;
    s = busy_set && (busy_wa == a);
    c = 1'b0;
    for (int j = 0; j < NWR; j++)
      if (we[j] && wa[4*j +: 4] == a) c = 1'b1;
    return m_busy[a] & ~(byp & c & ~s);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 15; r++) m_rf[r] = '0;
    m_busy = '0;
    m_err  = 1'b0;
  endtask

  task automatic model_clock();
    logic [14:0] clr;
    clr = '0;
    for (int j = 0; j < NWR; j++) begin
      if (we[j]) begin
        if (wa[4*j +: 4] == 4'hF) m_err = 1'b1;
        else begin
          m_rf[wa[4*j +: 4]] = wd[DW*j +: DW];
          clr[wa[4*j +: 4]]  = 1'b1;
        end
      end
    end
    for (int r = 0; r < 15; r++) begin
      if (busy_set && busy_wa == 4'(r)) m_busy[r] = 1'b1;
      else if (clr[r])                  m_busy[r] = 1'b0;
    end
  endtask

  // Push expectations for the currently driven inputs, in observation order.
  task automatic push_exp();
    logic [3:0] a;
    for (int k = 0; k < NRD; k++) begin
      a = ra[4*k +: 4];
      sb_q.push_back('{$sformatf("rd%0d_byp", k),   exp_rd(a, 1'b1)});
      sb_q.push_back('{$sformatf("busy%0d_byp", k), {31'd0, exp_busy(a, 1'b1)}});
      sb_q.push_back('{$sformatf("rd%0d_nob", k),   exp_rd(a, 1'b0)});
      sb_q.push_back('{$sformatf("busy%0d_nob", k), {31'd0, exp_busy(a, 1'b0)}});
    end
    sb_q.push_back('{"any_busy_byp", {31'd0, |m_busy}});
    sb_q.push_back('{"any_busy_nob", {31'd0, |m_busy}});
    sb_q.push_back('{"wr_pc_err_byp", {31'd0, m_err}});
    sb_q.push_back('{"wr_pc_err_nob", {31'd0, m_err}});
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check_val(e.tag, obs, e.val);
  endtask

  task automatic compare_out();
    for (int k = 0; k < NRD; k++) begin
      pop_cmp(rd_b[DW*k +: DW]);
      pop_cmp({31'd0, rdb_b[k]});
      pop_cmp(rd_n[DW*k +: DW]);
      pop_cmp({31'd0, rdb_n[k]});
    end
    pop_cmp({31'd0, any_b});
    pop_cmp({31'd0, any_n});
    pop_cmp({31'd0, err_b});
    pop_cmp({31'd0, err_n});
  endtask

  // One cycle: expectations, sample at negedge, advance model and clock.
  task automatic step();
    push_exp();
    @(negedge clk);
    compare_out();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; wa = '0; wd = '0; busy_set = 1'b0; busy_wa = 4'h0;
  endtask

  task automatic set_ra(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
    ra = {a2, a1, a0};
  endtask

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; r15 = 32'h8;
    idle(); set_ra(4'h0, 4'h3, 4'hF);
    model_clear();
    #2;
    check_val("rst_rd0", rd_b[31:0], 32'h0);
    check_val("rst_rd2_pc", rd_b[95:64], 32'h8);
    check_val("rst_any", {31'd0, any_b}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Populate state: R3, R1, busy R9, PC-write error
    we = 2'b01; wa = {4'h0, 4'h3}; wd = {32'h0, 32'hDEADBEEF}; step();
    we = 2'b10; wa = {4'h1, 4'h0}; wd = {32'h1111_0001, 32'h0}; busy_set = 1'b1; busy_wa = 4'h9; step();
    idle(); we = 2'b01; wa = {4'h0, 4'hF}; set_ra(4'h3, 4'h1, 4'h9); step();
    idle(); step();

    // Mid-cycle asynchronous reset with a write in progress to R6
    we = 2'b01; wa = {4'h0, 4'h6}; wd = {32'h0, 32'h6666_6666};
    reset = 1'b0;
    #1;
    check_val("areset_rd_r3", rd_n[31:0], 32'h0);
    check_val("areset_any", {31'd0, any_b}, 32'd0);
    check_val("areset_err", {31'd0, err_b}, 32'd0);
    model_clear();
    @(posedge clk); #1;
    reset = 1'b1;
    idle(); set_ra(4'h3, 4'h6, 4'h9); step();
    check_val("areset_r6_dropped", rd_n[63:32], 32'h0);

    // Dual write collision: highest port wins
    we = 2'b11; wa = {4'h5, 4'h5}; wd = {32'h22, 32'h11}; set_ra(4'h5, 4'h0, 4'h0); step();
    idle(); step();
    check_val("collide_r5", rd_n[31:0], 32'h22);

    // Bypass vs stored read
    we = 2'b01; wa = {4'h0, 4'h7}; wd = {32'h0, 32'h0000_1234}; step();
    idle(); we = 2'b01; wa = {4'h0, 4'h7}; wd = {32'h0, 32'hA5A5A5A5}; set_ra(4'h7, 4'h0, 4'h0);
    #1;
    check_val("byp_same_cycle", rd_b[31:0], 32'hA5A5A5A5);
    check_val("nob_same_cycle", rd_n[31:0], 32'h0000_1234);
    step();
    idle(); step();
    check_val("nob_next_cycle", rd_n[31:0], 32'hA5A5A5A5);

    // Scoreboard set, hold, clear
    busy_set = 1'b1; busy_wa = 4'h4; set_ra(4'h4, 4'h0, 4'h0); step();
    idle(); step();
    check_val("sb_busy4", {31'd0, rdb_b[0]}, 32'd1);
    check_val("sb_any", {31'd0, any_b}, 32'd1);
    we = 2'b01; wa = {4'h0, 4'h4}; wd = {32'h0, 32'h4444}; #1;
    check_val("sb_clr_byp", {31'd0, rdb_b[0]}, 32'd0);
    check_val("sb_clr_nob", {31'd0, rdb_n[0]}, 32'd1);
    step();
    idle(); step();
    check_val("sb_any_clear", {31'd0, any_n}, 32'd0);

    // Set and clear in the same cycle: set wins, data still written
    busy_set = 1'b1; busy_wa = 4'h2; set_ra(4'h2, 4'h2, 4'h0); step();
    busy_set = 1'b1; busy_wa = 4'h2; we = 2'b01; wa = {4'h0, 4'h2}; wd = {32'h0, 32'h55}; step();
    idle(); step();
    check_val("setclr_busy2", {31'd0, rdb_b[0]}, 32'd1);
    check_val("setclr_r2", rd_b[31:0], 32'h55);

    // PC read and illegal PC write
    r15 = 32'h108; set_ra(4'h2, 4'hF, 4'h0); step();
    check_val("pc_rd1", rd_b[63:32], 32'h108);
    we = 2'b01; wa = {4'h0, 4'hF}; wd = '0; step();
    idle(); step(); step();
    check_val("pc_err_sticky", {31'd0, err_n}, 32'd1);
    check_val("pc_rd1_after", rd_n[63:32], 32'h108);

    // Randomised traffic
    for (int i = 0; i < 60; i++) begin
      ra       = 12'($urandom);
      we       = 2'($urandom_range(0, 3));
      wa       = 8'($urandom);
      wd       = {$urandom, $urandom};
      r15      = $urandom;
      busy_set = ($urandom_range(0, 3) == 0);
      busy_wa  = 4'($urandom);
      step();
    end

    check_val("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
